// File: rtl/peripheral_spram_pkg.sv
// Shared types for the single-port RAM arbiter: FSM state and requester index.
package peripheral_spram_pkg;

    // INIT zero-fills the RAM; ARB serves the two requesters.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_e;

    // Index of one of the two requesters (0 or 1).
    typedef logic req_idx_t;

endpackage

// File: rtl/peripheral_spram_rr_arb.sv
// Two-way round-robin arbiter. The grant is combinational. The pointer names
// the requester that wins the next contended cycle.
module peripheral_spram_rr_arb
    import peripheral_spram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    req_idx_t   r_prio;
    logic [1:0] w_gnt;

    // A single request always wins. On contention, the pointer decides.
    always_comb begin
        w_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) begin
                w_gnt[r_prio] = 1'b1;
            end else begin
                w_gnt = i_req;
            end
        end
    end

    // Priority passes to the other requester only when a grant is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (w_gnt[0]) begin
            r_prio <= 1'b1;
        end else if (w_gnt[1]) begin
            r_prio <= 1'b0;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/peripheral_spram_arbiter.sv
// Two-requester front end for a single-port RAM. The block zero-fills the RAM
// after reset, then grants one access per cycle round-robin. Read data returns
// one cycle after the grant.
module peripheral_spram_arbiter
    import peripheral_spram_pkg::*;
#(
    parameter int AW       = 7,
    parameter int DW       = 16,
    parameter int MEM_SIZE = 256,
    parameter int INIT_EN  = 1
) (
    input  logic          ram_clk,
    input  logic          ram_rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_din,
    input  logic [1:0]    m0_we,
    output logic          m0_gnt,
    output logic [DW-1:0] m0_dout,
    output logic          m0_rvalid,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_din,
    input  logic [1:0]    m1_we,
    output logic          m1_gnt,
    output logic [DW-1:0] m1_dout,
    output logic          m1_rvalid,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_cen,
    output logic [1:0]    ram_wen,
    input  logic [DW-1:0] ram_dout,
    output logic          init_done
);

    localparam int DEPTH = MEM_SIZE / (DW / 8);

    state_e        r_state;
    logic [AW-1:0] r_cnt;
    logic [1:0]    r_rvld;
    logic [1:0]    w_gnt;
    logic          w_arb_en;
    logic          w_cnt_last;

    // While reset is held, every output is forced idle. This covers the
    // cycle before the registers have taken their reset values.
    assign w_arb_en   = (r_state == ST_ARB) && !ram_rst;
    assign w_cnt_last = (r_cnt == AW'(DEPTH - 1));

    peripheral_spram_rr_arb u_arb (
        .clk   (ram_clk),
        .rst   (ram_rst),
        .i_en  (w_arb_en),
        .i_req ({m1_req, m0_req}),
        .o_gnt (w_gnt)
    );

    // FSM and init counter: DEPTH zero writes, then arbitrate until reset.
    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            r_state <= (INIT_EN != 0) ? ST_INIT : ST_ARB;
            r_cnt   <= '0;
        end else if (r_state == ST_INIT) begin
            if (w_cnt_last) begin
                r_state <= ST_ARB;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    // One-stage read tracker: marks which requester's read data comes back
    // next cycle.
    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            r_rvld <= 2'b00;
        end else begin
            r_rvld <= {w_gnt[1] && (m1_we == 2'b00),
                       w_gnt[0] && (m0_we == 2'b00)};
        end
    end

    // RAM port mux. The init writer has the port during INIT; otherwise the
    // granted requester has it.
    always_comb begin
        ram_cen  = 1'b1;
        ram_wen  = 2'b11;
        ram_addr = '0;
        ram_din  = '0;
        if (!ram_rst) begin
            if (r_state == ST_INIT) begin
                ram_cen  = 1'b0;
                ram_wen  = 2'b00;
                ram_addr = r_cnt;
            end else if (w_gnt[0]) begin
                ram_cen  = 1'b0;
                ram_wen  = ~m0_we;
                ram_addr = m0_addr;
                ram_din  = m0_din;
            end else if (w_gnt[1]) begin
                ram_cen  = 1'b0;
                ram_wen  = ~m1_we;
                ram_addr = m1_addr;
                ram_din  = m1_din;
            end
        end
    end

    assign m0_gnt    = w_gnt[0];
    assign m1_gnt    = w_gnt[1];
    assign m0_rvalid = r_rvld[0] && !ram_rst;
    assign m1_rvalid = r_rvld[1] && !ram_rst;
    assign m0_dout   = m0_rvalid ? ram_dout : '0;
    assign m1_dout   = m1_rvalid ? ram_dout : '0;
    assign init_done = w_arb_en;

endmodule

// File: tb/tb_peripheral_spram_arbiter.sv
// Randomized scoreboard bench for peripheral_spram_arbiter. The reference holds
// an ideal byte-lane memory and the round-robin rule "last winner yields".
// Expected reads are queued at grant time, and a monitor pops each one a
// cycle later.
module tb_peripheral_spram_arbiter;

    logic        ram_clk = 1'b0;
    logic        ram_rst = 1'b1;
    logic        m0_req = 0, m1_req = 0;
    logic [6:0]  m0_addr = 0, m1_addr = 0;
    logic [15:0] m0_din = 0, m1_din = 0;
    logic [1:0]  m0_we = 0, m1_we = 0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [15:0] m0_dout, m1_dout;
    logic [6:0]  ram_addr;
    logic [15:0] ram_din;
    logic        ram_cen;
    logic [1:0]  ram_wen;
    logic [15:0] ram_dout = 0;
    logic        init_done;

    // Second instance with INIT_EN=0
    logic        u1_rst = 1'b1;
    logic        u1_m1_req = 1'b1;
    logic        u1_m0_gnt, u1_m1_gnt, u1_m0_rvalid, u1_m1_rvalid;
    logic [15:0] u1_m0_dout, u1_m1_dout;
    logic [6:0]  u1_ram_addr;
    logic [15:0] u1_ram_din;
    logic        u1_ram_cen;
    logic [1:0]  u1_ram_wen;
    logic [15:0] u1_ram_dout = 16'h0;
    logic        u1_init_done;
    logic        u1_m0_req = 1'b0;
    logic [6:0]  u1_addr = 7'd9;
    logic [15:0] u1_din = 16'hBEEF;
    logic [1:0]  u1_m0_we = 2'b00, u1_m1_we = 2'b11;

    always #5 ram_clk = ~ram_clk;

    peripheral_spram_arbiter dut (
        .ram_clk(ram_clk), .ram_rst(ram_rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_din(m0_din), .m0_we(m0_we),
        .m0_gnt(m0_gnt), .m0_dout(m0_dout), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_din(m1_din), .m1_we(m1_we),
        .m1_gnt(m1_gnt), .m1_dout(m1_dout), .m1_rvalid(m1_rvalid),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_cen(ram_cen),
        .ram_wen(ram_wen), .ram_dout(ram_dout), .init_done(init_done)
    );

    peripheral_spram_arbiter #(.INIT_EN(0)) dut1 (
        .ram_clk(ram_clk), .ram_rst(u1_rst),
        .m0_req(u1_m0_req), .m0_addr(u1_addr), .m0_din(u1_din), .m0_we(u1_m0_we),
        .m0_gnt(u1_m0_gnt), .m0_dout(u1_m0_dout), .m0_rvalid(u1_m0_rvalid),
        .m1_req(u1_m1_req), .m1_addr(u1_addr), .m1_din(u1_din), .m1_we(u1_m1_we),
        .m1_gnt(u1_m1_gnt), .m1_dout(u1_m1_dout), .m1_rvalid(u1_m1_rvalid),
        .ram_addr(u1_ram_addr), .ram_din(u1_ram_din), .ram_cen(u1_ram_cen),
        .ram_wen(u1_ram_wen), .ram_dout(u1_ram_dout), .init_done(u1_init_done)
    );

    // Physical RAM behind the DUT: byte-lane writes, one-cycle read latency
    logic [15:0] phys [0:127];
    always @(posedge ram_clk) begin
        if (!ram_cen) begin
            if (!ram_wen[0]) phys[ram_addr][7:0]  <= ram_din[7:0];
            if (!ram_wen[1]) phys[ram_addr][15:8] <= ram_din[15:8];
            ram_dout <= phys[ram_addr];
        end
    end

    int cyc_n = 0;
    always @(posedge ram_clk) cyc_n <= cyc_n + 1;

    typedef struct {
        int          who;
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t        q[$];
    logic [15:0] ref_mem [0:127];
    int          last_g;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // Monitor: a queued read is due exactly one cycle after its grant.
    initial begin
        exp_t e;
        forever begin
            @(negedge ram_clk);
            if (q.size() > 0 && q[0].cyc == cyc_n - 1) begin
                e = q.pop_front();
                chk("rvalid0", {31'd0, m0_rvalid}, {31'd0, e.who == 0});
                chk("rvalid1", {31'd0, m1_rvalid}, {31'd0, e.who == 1});
                chk("rdata", {16'd0, (e.who == 0) ? m0_dout : m1_dout}, {16'd0, e.data});
            end else begin
                chk("idle_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
                chk("idle_dout", {m1_dout, m0_dout}, 32'd0);
            end
        end
    end

    // One arbitrated cycle: drive, then check the grant and RAM port against the model
    task automatic step(input logic r0, input logic [6:0] a0, input logic [15:0] d0,
                        input logic [1:0] w0, input logic r1, input logic [6:0] a1,
                        input logic [15:0] d1, input logic [1:0] w1, output logic [1:0] g);
        int          win;
        logic [6:0]  a;
        logic [15:0] d;
        logic [1:0]  w;
        exp_t        e;
        @(posedge ram_clk); #1;
        m0_req = r0; m0_addr = a0; m0_din = d0; m0_we = w0;
        m1_req = r1; m1_addr = a1; m1_din = d1; m1_we = w1;
        @(negedge ram_clk);
        win = -1;
        if (r0 && r1) win = 1 - last_g;
        else if (r0)  win = 0;
        else if (r1)  win = 1;
        chk("gnt", {30'd0, m1_gnt, m0_gnt},
            (win < 0) ? 32'd0 : ((win == 0) ? 32'd1 : 32'd2));
        if (win >= 0) begin
            a = (win == 0) ? a0 : a1;
            d = (win == 0) ? d0 : d1;
            w = (win == 0) ? w0 : w1;
            chk("cen", {31'd0, ram_cen}, 32'd0);
            chk("ram_addr", {25'd0, ram_addr}, {25'd0, a});
            chk("ram_wen", {30'd0, ram_wen}, {30'd0, ~w});
            chk("ram_din", {16'd0, ram_din}, {16'd0, d});
            if (w == 2'b00) begin
                e.who = win; e.data = ref_mem[a]; e.cyc = cyc_n;
                q.push_back(e);
            end else begin
                if (w[0]) ref_mem[a][7:0]  = d[7:0];
                if (w[1]) ref_mem[a][15:8] = d[15:8];
            end
            last_g = win;
        end else begin
            chk("cen_idle", {29'd0, ram_cen, ram_wen}, 32'd7);
        end
        g = {m1_gnt, m0_gnt};
    endtask

    // Assert reset for one cycle, then watch the full zero-fill sequence
    task automatic reset_and_init();
        @(posedge ram_clk); #1;
        ram_rst = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 2'b00; m1_we = 2'b00;
        q.delete();
        @(negedge ram_clk);
        chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        chk("rst_ram", {29'd0, ram_cen, ram_wen}, 32'd7);
        chk("rst_done", {31'd0, init_done}, 32'd0);
        chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        last_g = 1;
        for (int i = 0; i < 128; i++) ref_mem[i] = 16'h0;
        for (int i = 0; i < 128; i++) begin
            @(posedge ram_clk); #1;
            ram_rst = 1'b0;
            m0_req = 1'($urandom); m1_req = 1'($urandom);
            @(negedge ram_clk);
            chk("init_port", {ram_cen, ram_wen, ram_din, 6'd0, ram_addr},
                {1'b0, 2'b00, 16'h0, 6'd0, 7'(i)});
            chk("init_gnt", {29'd0, init_done, m1_gnt, m0_gnt}, 32'd0);
        end
        @(posedge ram_clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge ram_clk);
        chk("init_done", {31'd0, init_done}, 32'd1);
        chk("post_init_idle", {31'd0, ram_cen}, 32'd1);
    endtask

    initial begin
        logic [1:0] g;
        for (int i = 0; i < 128; i++) phys[i] = 16'($urandom);
        repeat (2) @(posedge ram_clk);
        reset_and_init();

        // Full write then read back on m0
        step(1, 7'd5, 16'hA5A5, 2'b11, 0, 7'd0, 16'h0, 2'b00, g);
        step(1, 7'd5, 16'h0000, 2'b00, 0, 7'd0, 16'h0, 2'b00, g);
        step(0, 7'd0, 16'h0000, 2'b00, 0, 7'd0, 16'h0, 2'b00, g);
        chk("rd_a5a5", {16'd0, m0_dout}, 32'h0000A5A5);

        // Low-byte-only write from m1 merges into an existing word
        step(1, 7'd3, 16'h1234, 2'b11, 0, 7'd0, 16'h0, 2'b00, g);
        step(0, 7'd0, 16'h0000, 2'b00, 1, 7'd3, 16'hFFCD, 2'b01, g);
        step(1, 7'd3, 16'h0000, 2'b00, 0, 7'd0, 16'h0, 2'b00, g);
        step(0, 7'd0, 16'h0000, 2'b00, 0, 7'd0, 16'h0, 2'b00, g);
        chk("rd_partial", {16'd0, m0_dout}, 32'h000012CD);

        // Random traffic on a small address window
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 6), 7'($urandom_range(0, 15)), 16'($urandom),
                 (($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom)),
                 ($urandom_range(0, 9) < 6), 7'($urandom_range(0, 15)), 16'($urandom),
                 (($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom)), g);
        end

        // Reset one cycle after a granted read: no rvalid, INIT restarts at 0
        step(1, 7'd5, 16'h0, 2'b00, 0, 7'd0, 16'h0, 2'b00, g);
        reset_and_init();

        // Continuous contention alternates, starting with m0 after reset
        for (int i = 0; i < 6; i++) begin
            step(1, 7'($urandom_range(0, 127)), 16'h0, 2'b00,
                 1, 7'($urandom_range(0, 127)), 16'h0, 2'b00, g);
            chk("alternate", {30'd0, g}, (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        step(0, 7'd0, 16'h0, 2'b00, 0, 7'd0, 16'h0, 2'b00, g);
        step(0, 7'd0, 16'h0, 2'b00, 0, 7'd0, 16'h0, 2'b00, g);
        chk("sb_drained", q.size(), 32'd0);

        // INIT_EN=0: arbitration is live in the first cycle after reset
        @(posedge ram_clk); #1;
        u1_rst = 1'b1;
        @(negedge ram_clk);
        chk("u1_rst", {29'd0, u1_init_done, u1_m1_gnt, u1_m0_gnt}, 32'd0);
        @(posedge ram_clk); #1;
        u1_rst = 1'b0;
        @(negedge ram_clk);
        chk("u1_first", {28'd0, u1_init_done, u1_m1_gnt, u1_m0_gnt, u1_ram_cen}, 32'b1100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/peripheral_spram_arbiter.md
PERIPHERAL_SPRAM_ARBITER -- requirements
Module: peripheral_spram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 7, RAM word-address width.
REQ-002 SHALL have parameter DW, default 16, RAM data width (two byte lanes).
REQ-003 SHALL have parameter MEM_SIZE, default 256, memory size in bytes; DEPTH = MEM_SIZE/(DW/8) words, DEPTH <= 2**AW.
REQ-004 SHALL have parameter INIT_EN, default 1, 1 = zero-fill RAM after reset.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as follows (clock and reset first):
- ram_clk  in  1  clock (rising edge)
- ram_rst  in  1  reset
- mN_req  in  1  requester N access request (N = 0, 1)
- mN_addr  in  AW  requester N word address
- mN_din  in  DW  requester N write data
- mN_we  in  2  requester N byte write enables (active high); 00 = read
- mN_gnt  out  1  access accepted this cycle
- mN_dout  out  DW  read data
- mN_rvalid  out  1  mN_dout valid
- ram_addr  out  AW  to RAM
- ram_din  out  DW  to RAM
- ram_cen  out  1  RAM chip enable (low active)
- ram_wen  out  2  RAM byte write enables (low active)
- ram_dout  in  DW  from RAM; valid one cycle after a read
- init_done  out  1  high once init is complete

Function
REQ-006 SHALL implement FSM states INIT and ARB; reset enters INIT if INIT_EN=1, else ARB.
REQ-007 In INIT: SHALL write zero to word cnt each cycle (ram_cen=0, ram_wen=2'b00, ram_din=0) with cnt counting 0..DEPTH-1, then enter ARB the cycle after cnt=DEPTH-1 is written; DEPTH write cycles total.
REQ-008 In INIT: SHALL hold both mN_gnt=0 regardless of mN_req; init_done=0.
REQ-009 In ARB: SHALL set init_done=1, held until reset.
REQ-010 In ARB: mN_gnt SHALL be combinational, in the same cycle as mN_req; at most one grant per cycle; one RAM access per cycle, no bubbles.
REQ-011 Arbitration SHALL be round-robin: a single requester wins; on contention the requester not granted most recently wins; the priority pointer updates only on a grant; after reset requester 0 has priority.
REQ-012 On a grant: ram_cen=0, ram_addr=mN_addr, ram_din=mN_din, ram_wen=~mN_we; with no grant: ram_cen=1, ram_wen=2'b11, ram_addr/ram_din=0.
REQ-013 A granted read (mN_we=00) SHALL assert mN_rvalid exactly one cycle later with mN_dout=ram_dout; the other requester's rvalid stays 0.
REQ-014 A granted write SHALL produce no rvalid; a partial write (01/10) modifies only the enabled byte lane.
REQ-015 Back-to-back reads from alternating requesters SHALL each return one cycle after grant, in grant order, with no data loss.
REQ-016 mN_dout SHALL be 0 whenever mN_rvalid=0.
REQ-017 A requester holding req SHALL wait at most one cycle under continuous contention (no starvation).

Reset
REQ-018 Reset SHALL force: state=INIT (or ARB if INIT_EN=0), cnt=0, pointer=requester 0, rvalid pipeline cleared, init_done=0, all mN_gnt=0, mN_rvalid=0, mN_dout=0, ram_cen=1, ram_wen=2'b11.
REQ-019 Reset asserted mid-INIT or mid-read SHALL discard the pending rvalid and restart INIT at cnt=0.

Structure
REQ-020 Package peripheral_spram_pkg SHALL hold the FSM state enum (INIT, ARB) and the requester-index typedef.
REQ-021 The 2-way round-robin grant logic with its pointer register SHALL be sub-module peripheral_spram_rr_arb; the FSM, init counter, RAM muxing and rvalid pipeline stay in the top level.

Verification
REQ-022 Reset release, INIT_EN=1, defaults -> 128 consecutive cycles with ram_cen=0, ram_wen=00, ram_din=0, addresses 0..127; init_done rises the cycle after; no grants meanwhile.
REQ-023 m0 write 0xA5A5 to addr 5, then m0 read addr 5 -> m0_gnt in request cycles; m0_rvalid=1 with m0_dout=0xA5A5 one cycle after the read grant; m1_rvalid=0.
REQ-024 m0 and m1 both hold req for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1.
REQ-025 After filling addr 3 with 0x1234, m1 write with we=01, data 0xFFCD -> readback 0x12CD.
REQ-026 ram_rst asserted one cycle after a granted read -> no rvalid; INIT restarts at cnt=0.
REQ-027 INIT_EN=0 -> init_done=1 and m1 request granted in the first cycle after reset.
